// File: rtl/snn_pkg.sv
// Shared SNN definitions: channel count, default widths and encoder FSM states.
// Used by the spike encoder, the neuron and the synapse blocks.
// No ports; constants and types only.
package snn_pkg;

  // Synapse / channel count of the neuron array.
  localparam int SNN_S      = 42;
  // Default intensity width; an encoding window is 2^SNN_WIDTH steps.
  localparam int SNN_WIDTH  = 8;
  // Default prescale width.
  localparam int SNN_PWIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/spike_encoder42s_step_timer.sv
// Step timer: prescale counter c (0..P, wraps) plus step counter s.
// Ports: i_clk, i_rst_n, i_clr (zero both counters), i_en (count), i_prescale (P),
//        o_bound (c==0), o_step (s), o_last (c==P on the final step).
module spike_encoder42s_step_timer #(
  parameter int p_width  = 8,
  parameter int p_pwidth = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [p_pwidth-1:0] i_prescale,
  output logic                o_bound,
  output logic [p_width-1:0]  o_step,
  output logic                o_last
);

  logic [p_pwidth-1:0] c_q, c_d;
  logic [p_width-1:0]  s_q, s_d;
  logic                wrap;

  assign wrap    = (c_q == i_prescale);
  assign o_bound = (c_q == '0);
  assign o_step  = s_q;
  assign o_last  = wrap && (s_q == {p_width{1'b1}});

  always_comb begin
    c_d = c_q;
    s_d = s_q;
    if (i_clr) begin
      c_d = '0;
      s_d = '0;
    end else if (i_en) begin
      if (wrap) begin
        c_d = '0;
        s_d = s_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c_q <= '0;
      s_q <= '0;
    end else begin
      c_q <= c_d;
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/spike_encoder42s.sv
// Time-to-first-spike encoder: 42 intensities -> one-cycle spikes, brighter fires earlier.
// Ports: i_clk, i_rst_n, i_start/i_stop (window control), i_pixel (packed intensities),
//        i_prescale (cycles per step - 1), o_event[42:1], o_step, o_busy, o_done.
module spike_encoder42s
  import snn_pkg::*;
#(
  parameter int p_width  = SNN_WIDTH,
  parameter int p_s      = SNN_S,
  parameter int p_pwidth = SNN_PWIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [p_s*p_width-1:0]   i_pixel,
  input  logic [p_pwidth-1:0]      i_prescale,
  output logic [p_s:1]             o_event,
  output logic [p_width-1:0]       o_step,
  output logic                     o_busy,
  output logic                     o_done
);

  enc_state_e               state_q, state_d;
  logic [p_s*p_width-1:0]   pix_q, pix_d;
  logic [p_pwidth-1:0]      pre_q, pre_d;
  logic [p_s:1]             fired_q, fired_d;
  logic [p_s:1]             event_q, event_d;
  logic [p_width-1:0]       step_q, step_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     start_acc;
  logic                     run_live;
  logic                     t_bound;
  logic                     t_last;
  logic [p_width-1:0]       t_step;
  logic [p_s:1]             fire_vec;

  // A start is only honoured in IDLE; a stop only matters once a window is active.
  assign start_acc = (state_q == ST_IDLE) && i_start;
  // RUN cycle that is not being aborted: the only cycles that may emit spikes.
  assign run_live  = (state_q == ST_RUN) && !i_stop;

  spike_encoder42s_step_timer #(
    .p_width  (p_width),
    .p_pwidth (p_pwidth)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (start_acc),
    .i_en       (state_q == ST_RUN),
    .i_prescale (pre_q),
    .o_bound    (t_bound),
    .o_step     (t_step),
    .o_last     (t_last)
  );

  // Channel i fires on the step (2^w-1)-pix at the first cycle of that step.
  // Zero intensity would map onto the final step, so it is excluded explicitly.
  for (genvar gi = 1; gi <= p_s; gi++) begin : g_ch
    logic [p_width-1:0] pix;
    assign pix          = pix_q[gi*p_width-1 -: p_width];
    assign fire_vec[gi] = t_bound && (pix != '0) &&
                          (t_step == ({p_width{1'b1}} - pix)) && !fired_q[gi];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_RUN;
      ST_RUN: begin
        if (i_stop)      state_d = ST_IDLE;
        else if (t_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_d   = pix_q;
    pre_d   = pre_q;
    fired_d = fired_q;
    if (start_acc) begin
      pix_d   = i_pixel;
      pre_d   = i_prescale;
      fired_d = '0;
    end else if (run_live) begin
      fired_d = fired_q | fire_vec;
    end
    // Outputs are registered views of the cycle just finished, so an abort
    // clears them on the same edge that leaves RUN/DONE.
    event_d = run_live ? fire_vec : '0;
    step_d  = run_live ? t_step : '0;
    busy_d  = run_live;
    done_d  = (state_q == ST_DONE) && !i_stop;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      pre_q   <= '0;
      fired_q <= '0;
      event_q <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      pre_q   <= pre_d;
      fired_q <= fired_d;
      event_q <= event_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_event = event_q;
  assign o_step  = step_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_spike_encoder42s.sv
module tb_spike_encoder42s;

  localparam int S  = 42;
  localparam int WD = 8;
  localparam longint INF = 64'd1000000000;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_start = 1'b0;
  logic            i_stop = 1'b0;
  logic [S*WD-1:0] i_pixel = '0;
  logic [7:0]      i_prescale = '0;
  logic [S:1]      o_event;
  logic [7:0]      o_step;
  logic            o_busy;
  logic            o_done;

  always #5 i_clk = ~i_clk;

  spike_encoder42s dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_pixel    (i_pixel),
    .i_prescale (i_prescale),
    .o_event    (o_event),
    .o_step     (o_step),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  int checks = 0;
  int passed = 0;

  // Model state: one window described by its start edge, prescale, pixels and stop edge.
  longint      n_edge = 0;
  bit          chk_en = 1'b0;
  bit          m_have = 1'b0;
  longint      m_k = 0, m_t = INF, m_W = 0;
  int          m_P = 0;
  logic [S*WD-1:0] m_pix = '0;

  // Observations relative to the start edge, pinned against hand-computed literals.
  longint f_e1, f_e2, f_e3, f_e5, f_e9, f_dn;
  int     busy_cnt, ev_cnt, w_e5;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, n_edge);
  endtask

  function automatic bit start_ok(input longint n);
    if (!m_have) return 1'b1;
    if (m_t != INF) return n >= m_t + 1;
    return n >= m_k + m_W + 2;
  endfunction

  always @(posedge i_clk) begin
    if (chk_en) begin
      logic [S:1] ev;
      bit bz, dn;
      longint rel, stp;
      n_edge++;
      if (start_ok(n_edge)) begin
        if (i_start) begin
          m_k = n_edge; m_P = int'(i_prescale); m_W = 256 * (m_P + 1);
          m_pix = i_pixel; m_t = INF; m_have = 1'b1;
          f_e1 = -1; f_e2 = -1; f_e3 = -1; f_e5 = -1; f_e9 = -1; f_dn = -1;
          busy_cnt = 0; ev_cnt = 0; w_e5 = 0;
        end
      end else if (i_stop && m_t == INF && n_edge >= m_k + 1 && n_edge <= m_k + m_W + 1) begin
        m_t = n_edge;
      end
      #1;
      ev = '0; bz = 1'b0; dn = 1'b0; stp = 0;
      rel = n_edge - m_k;
      if (m_have && n_edge < m_t) begin
        bz = (rel >= 1) && (rel <= m_W);
        dn = (rel == m_W + 1);
        if (bz) begin
          stp = (rel - 1) / (m_P + 1);
          if ((rel - 1) % (m_P + 1) == 0)
            for (int c = 1; c <= S; c++) begin
              int px;
              px = int'(m_pix[c*WD-1 -: WD]);
              if (px != 0 && 255 - px == stp) ev[c] = 1'b1;
            end
        end
      end
      chk("event", longint'(o_event), longint'(ev));
      chk("busy", longint'(o_busy), longint'(bz));
      chk("done", longint'(o_done), longint'(dn));
      if (bz) chk("step", longint'(o_step), stp);
      if (o_event[1] && f_e1 < 0) f_e1 = rel;
      if (o_event[2] && f_e2 < 0) f_e2 = rel;
      if (o_event[3] && f_e3 < 0) f_e3 = rel;
      if (o_event[5] && f_e5 < 0) f_e5 = rel;
      if (o_event[9] && f_e9 < 0) f_e9 = rel;
      if (o_done && f_dn < 0) f_dn = rel;
      if (o_busy) busy_cnt++;
      if (o_event != '0) ev_cnt++;
      if (o_event[5]) w_e5++;
    end
  end

  // Called at a negedge; the start is sampled on the following rising edge.
  task automatic do_start(input logic [S*WD-1:0] px, input int p);
    i_pixel = px; i_prescale = 8'(p); i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (o_done) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  function automatic logic [S*WD-1:0] set_ch(input logic [S*WD-1:0] v, input int c, input int px);
    logic [S*WD-1:0] r;
    r = v;
    r[c*WD-1 -: WD] = 8'(px);
    return r;
  endfunction

  initial begin
    logic [S*WD-1:0] px;
    int w, r;
    // Reset values with no rising edge seen yet.
    #2;
    chk("rst_event", longint'(o_event), 0);
    chk("rst_busy", longint'(o_busy), 0);
    chk("rst_done", longint'(o_done), 0);
    chk("rst_step", longint'(o_step), 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    chk_en  = 1'b1;
    @(negedge i_clk);

    // Brightest channel fires at once, mid intensity at step 127.
    px = '0; px = set_ch(px, 1, 255); px = set_ch(px, 2, 128);
    do_start(px, 0);
    wait_done();
    chk("t1_e1_rel", f_e1, 1);
    chk("t1_e2_rel", f_e2, 128);
    chk("t1_done_rel", f_dn, 257);

    // Equal intensities share a cycle; prescale stretches steps.
    px = '0; px = set_ch(px, 5, 200); px = set_ch(px, 9, 200);
    do_start(px, 3);
    wait_done();
    chk("t2_e5_rel", f_e5, 221);
    chk("t2_e9_rel", f_e9, 221);
    chk("t2_e5_width", w_e5, 1);

    // Dark frame: no events, full-length busy, one done.
    do_start('0, 1);
    wait_done();
    chk("t3_busy_len", busy_cnt, 512);
    chk("t3_events", ev_cnt, 0);
    chk("t3_done_rel", f_dn, 513);

    // Mid-window pixel/prescale change and restart are ignored.
    px = '0; px = set_ch(px, 1, 100);
    do_start(px, 0);
    repeat (50) @(negedge i_clk);
    i_pixel = set_ch(px, 1, 250); i_prescale = 8'd5; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_done();
    chk("t4_e1_rel", f_e1, 156);

    // Abort around step 10, restart two cycles later; early channels fire again.
    px = '0; px = set_ch(px, 3, 250); px = set_ch(px, 1, 255);
    do_start(px, 0);
    repeat (10) @(negedge i_clk);
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
    chk("t5_busy_after_stop", longint'(o_busy), 0);
    @(negedge i_clk);
    do_start(px, 0);
    wait_done();
    chk("t5_e1_rel", f_e1, 1);
    chk("t5_e3_rel", f_e3, 6);
    chk("t5_done_rel", f_dn, 257);

    // Randomized windows, some aborted at a random point.
    for (int it = 0; it < 8; it++) begin
      px = '0;
      for (int c = 1; c <= S; c++) begin
        r = int'($urandom_range(0, 9));
        if (r < 4)      px = set_ch(px, c, 0);
        else if (r < 6) px = set_ch(px, c, (r == 4) ? 255 : 1);
        else if (r < 7) px = set_ch(px, c, 200);
        else            px = set_ch(px, c, int'($urandom_range(0, 255)));
      end
      w = int'($urandom_range(0, 2));
      do_start(px, w);
      if ($urandom_range(0, 1) == 1) begin
        r = int'($urandom_range(0, 256 * (w + 1)));
        repeat (r) @(negedge i_clk);
        i_stop = 1'b1;
        @(negedge i_clk);
        i_stop = 1'b0;
        repeat (int'($urandom_range(1, 3))) @(negedge i_clk);
      end else begin
        repeat (int'($urandom_range(5, 200))) @(negedge i_clk);
        i_pixel = ~px; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done();
      end
    end

    // Asynchronous reset mid-window clears outputs without a clock edge.
    px = '0;
    for (int c = 1; c <= S; c++) px = set_ch(px, c, 255 - c);
    do_start(px, 0);
    repeat (30) @(negedge i_clk);
    #2;
    chk_en  = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk("arst_event", longint'(o_event), 0);
    chk("arst_busy", longint'(o_busy), 0);
    chk("arst_step", longint'(o_step), 0);
    chk("arst_done", longint'(o_done), 0);
    repeat (3) @(negedge i_clk);
    chk("arst_no_done", longint'(o_done), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spike_encoder42s.md
# spike_encoder42s

Time-to-first-spike (latency) encoder that converts 42 unsigned input intensities into one-cycle spike pulses for the 42-synapse neuron array. It sits upstream of each neuron: its `o_event[42:1]` drives the neuron `i_event[42:1]` bus directly. Brighter inputs fire earlier, and each channel fires at most once per encoding window. A start/busy/done handshake lets the controller frame one sample per window.

## Interface
- `p_width`, 8: intensity width; the window is 2^p_width steps.
- `p_s`, 42: channel count; fixed at 42 for this block.
- `p_pwidth`, 8: prescale width.

Ports (clock and reset first):
- `i_clk`  in  1  sole clock; all logic is on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  starts a window when sampled high in IDLE.
- `i_stop`  in  1  synchronous abort.
- `i_pixel`  in  `p_s*p_width`  intensities; channel i is `[i*p_width-1:(i-1)*p_width]`, matching the neuron weight packing.
- `i_prescale`  in  `p_pwidth`  P; each step lasts P+1 cycles.
- `o_event`  out  `[42:1]`  registered spike pulses.
- `o_step`  out  `p_width`  current step index.
- `o_busy`  out  1  high in RUN.
- `o_done`  out  1  one-cycle pulse at the end of a window.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when `i_start`=1.
  - On that edge, latch `i_pixel` and `i_prescale` into internal registers.
  - Clear the step counter s and the prescale counter c to 0.
  - Clear the per-channel fired mask.
- RUN, step boundary (c==0): for each channel i, `o_event[i]` <= (pix_i != 0) && (s == 2^p_width-1-pix_i) && !fired_i.
  - When an event is set, also set fired_i.
  - All other cycles: `o_event` <= 0.
- c counts 0..P and then wraps. When c==P, s increments.
- When c==P and s==2^p_width-1: RUN -> DONE.
- DONE: `o_done`=1 for one cycle, then -> IDLE.
- Channel mapping:
  - pix = 255 fires at step 0.
  - pix = 1 fires at step 254.
  - pix = 0 never fires.
  - Step 255 never carries an event.
- `i_start` is ignored in RUN and DONE. Latched values are immune to `i_pixel`/`i_prescale` changes during RUN.
- `i_stop`=1 in RUN or DONE:
  - Next state is IDLE.
  - `o_event`, `o_busy` and `o_done` go to 0 on the next edge.
  - No `o_done` pulse is produced.
  - `i_stop` has priority over `i_start` and over window completion.
- Multiple channels with equal intensity fire in the same cycle.

## Timing
- Reset values: `o_event`=0, `o_step`=0, `o_busy`=0, `o_done`=0, state IDLE, all internal registers 0.
- An asynchronous reset mid-window aborts immediately, with no `o_done`.
- Start at edge k:
  - `o_busy`=1 from cycle k+1.
  - The step-s event pulse is high for exactly cycle k+1+s*(P+1).
  - `o_step`=s throughout that step.
- Window length in RUN is 2^p_width*(P+1) cycles.
  - `o_done` is high the cycle after the last RUN cycle. `o_busy`=0 in that cycle.
  - IDLE follows one cycle later; a new `i_start` is accepted from then on.
- P=0 gives one step per cycle, so back-to-back steps are legal.

## Structure
- Shared package `snn_pkg` holds:
  - the channel count 42;
  - the FSM state enum (IDLE/RUN/DONE);
  - the default p_width and prescale width, shared with the neuron and synapse.
- One natural sub-module is `step_timer`: the prescale counter c plus the step counter s.
  - Outputs: step-boundary strobe, `o_step`, last-step flag.
  - Inputs: clear and enable.
- Per-channel compare and fired mask are a generate loop over 1..42 in the top module.

## Test plan
- Reset, P=0, pixel1=255, pixel2=128, others 0; start at edge k -> `o_event[1]` at cycle k+1, `o_event[2]` at cycle k+128, no other events, `o_done` at cycle k+257.
- P=3, pixel5=pixel9=200 -> both fire in the same cycle, k+1+55*4=k+221; each pulse is 1 cycle wide.
- All pixels 0 -> no events for the whole window; `o_busy` high for 256*(P+1) cycles, then one `o_done` pulse.
- Change `i_pixel` and pulse `i_start` mid-RUN -> ignored; event timing follows the originally latched values.
- `i_stop` at step 10, then `i_start` two cycles later -> no `o_done`; the new window restarts from step 0 and the channels that had fired fire again.
- Assert `i_rst_n`=0 mid-window, asynchronously -> all outputs 0 immediately, with no clock edge required.
